// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: shared segment patterns, BCD limit and digit decoder
package bcd_display_pkg;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD decade with clamped load, up/down step and limit flags for the ripple chain
module bcd_digit
  import bcd_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       carry,
  output logic       borrow
);
  logic [3:0] r_q;
  always_ff @(posedge clk) begin
    if (!rst) r_q <= '0;
    else if (load) r_q <= (load_val > BCD_MAX) ? BCD_MAX : load_val;
    else if (step) r_q <= up ? ((r_q == BCD_MAX) ? 4'd0 : r_q + 4'd1)
                             : ((r_q == 4'd0) ? BCD_MAX : r_q - 4'd1);
  end
  assign q      = r_q;
  assign carry  = up && (r_q == BCD_MAX);
  assign borrow = !up && (r_q == 4'd0);
endmodule

// File: rtl/bcd_count_display.sv
// bcd_count_display: divided up/down BCD counter with 7-seg decode; BCD_COUNT_DISPLAY_LEADING_BLANK_EN blanks leading zeros
module bcd_count_display
  import bcd_display_pkg::*;
#(
  parameter int DIGITS   = 5,
  parameter int TICK_DIV = 25000000,
  parameter int WRAP     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   segs,
  output logic                  tc
);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  logic [DW-1:0]     r_div;
  logic              w_tick;
  logic              w_step0;
  logic [DIGITS-1:0] w_carry;
  logic [DIGITS-1:0] w_borrow;
  logic [DIGITS-1:0] w_term;
  logic [DIGITS-1:0] w_step;
  assign w_tick = ena && (r_div == DIV_LAST);
  always_ff @(posedge clk) begin
    if (!rst) r_div <= '0;
    else if (load) r_div <= '0;
    else if (ena) r_div <= w_tick ? '0 : r_div + DW'(1);
  end
  assign w_term  = w_carry | w_borrow;
  assign tc      = &w_term;
  assign w_step0 = w_tick && !load && ((WRAP != 0) || !tc);
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      if (g == 0) begin : g_lsd
        assign w_step[0] = w_step0;
      end else begin : g_hi
        assign w_step[g] = w_step0 && (&w_term[g-1:0]);
      end
      bcd_digit u_digit (
        .clk      (clk),
        .rst      (rst),
        .step     (w_step[g]),
        .up       (dir),
        .load     (load),
        .load_val (load_val[4*g +: 4]),
        .q        (bcd[4*g +: 4]),
        .carry    (w_carry[g]),
        .borrow   (w_borrow[g])
      );
`ifdef BCD_COUNT_DISPLAY_LEADING_BLANK_EN
      if (g == 0) begin : g_seg0
        assign segs[6:0] = seg_of(bcd[3:0]);
      end else begin : g_segn
        assign segs[7*g +: 7] = (bcd[4*DIGITS-1:4*g] == '0) ? SEG_BLANK : seg_of(bcd[4*g +: 4]);
      end
`else
      assign segs[7*g +: 7] = seg_of(bcd[4*g +: 4]);
`endif
    end
  endgenerate
endmodule

// File: doc/bcd_count_display.md
BCD_COUNT_DISPLAY -- requirements
Module: bcd_count_display

Interface
REQ-001 SHALL have parameter DIGITS, default 5, number of BCD decades (range 1-8).
REQ-002 SHALL have parameter TICK_DIV, default 25000000, clk cycles per count step (>=2).
REQ-003 SHALL have parameter WRAP, default 1; 1 = roll over at limits, 0 = saturate at limits.
REQ-004 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port ena, input, 1, count enable; gates the divider and the stepping.
REQ-007 SHALL have port dir, input, 1, 1 = count up, 0 = count down.
REQ-008 SHALL have port load, input, 1, synchronous parallel load strobe.
REQ-009 SHALL have port load_val, input, 4*DIGITS, BCD load value, digit 0 in bits [3:0].
REQ-010 SHALL have port bcd, output, 4*DIGITS, current count, digit 0 in bits [3:0].
REQ-011 SHALL have port segs, output, 7*DIGITS, active-low seven-segment patterns, digit 0 in bits [6:0], bit order g..a.
REQ-012 SHALL have port tc, output, 1, terminal-count flag.

Function
REQ-013 SHALL keep a divider counting 0..TICK_DIV-1 while ena=1, hold it while ena=0, and raise an internal tick for exactly the cycle in which it equals TICK_DIV-1 with ena=1.
REQ-014 SHALL step bcd by one decimal unit in dir on the clock edge where tick=1, with ripple carry/borrow across decades in the same edge.
REQ-015 SHALL, on load=1, write load_val into bcd on that edge, clear the divider, and ignore tick; load takes priority over stepping and works regardless of ena.
REQ-016 SHALL clamp any loaded nibble greater than 9 to 9.
REQ-017 SHALL, with WRAP=1, go from all-9s to all-0s counting up and from all-0s to all-9s counting down.
REQ-018 SHALL, with WRAP=0, hold at all-9s counting up and at all-0s counting down.
REQ-019 SHALL drive tc combinationally high when (dir=1 and bcd is all-9s) or (dir=0 and bcd is all-0s).
REQ-020 SHALL decode segs combinationally from bcd, with zero latency relative to bcd.
REQ-021 SHALL apply a dir change mid-interval at the next tick, and SHALL NOT reset the divider on a dir change.

Reset
REQ-022 SHALL, when rst=0 at a clock edge, clear bcd to 0 and the divider to 0 and suppress tick; rst overrides load and ena.
REQ-023 SHALL drive segs to 7'b1000000 in every digit after reset, or the blanking pattern of REQ-025 when that macro is defined.
REQ-024 SHALL behave identically for reset asserted mid-count, abandoning any partial interval.

Configuration
REQ-025 SHALL, with macro BCD_COUNT_DISPLAY_LEADING_BLANK_EN defined, drive 7'b1111111 on every digit above digit 0 whose own and all higher digits are zero; digit 0 always shows its value.
REQ-026 SHALL, without BCD_COUNT_DISPLAY_LEADING_BLANK_EN, display every digit including leading zeros; bcd and tc are unaffected either way.

Structure
REQ-027 SHALL take the ten active-low segment constants, the blank pattern, and the BCD max-digit constant (4'd9) from a shared package bcd_display_pkg.
REQ-028 SHALL instantiate one sub-module bcd_digit per decade (4-bit state, inputs step/up/load, outputs carry/borrow), generated DIGITS times.

Verification
REQ-029 SHALL cover this case with DIGITS=2, TICK_DIV=4, ena=1, dir=1 after reset: bcd=8'h00, then steps to 8'h01 four cycles after release, 8'h02 four cycles later.
REQ-030 SHALL cover this case: load 8'h99 with WRAP=1, dir=1, then one tick later bcd=8'h00; with WRAP=0, bcd stays 8'h99 and tc=1.
REQ-031 SHALL cover this case: load 8'h10, dir=0, one tick: bcd=8'h09 (borrow across decade); load 8'h00, WRAP=1: next tick bcd=8'h99.
REQ-032 SHALL cover this case: load=1 and tick coincide with load_val=8'h3F: bcd=8'h39 (clamped), divider restarts at 0.
REQ-033 SHALL cover this case: ena=0 for 10 cycles mid-interval: bcd and divider unchanged; resume completes the remaining interval only.
REQ-034 SHALL cover this case: rst=0 asserted together with load=1, load_val=8'h55: bcd=8'h00; with LEADING_BLANK_EN, segs=14'b1111111_1000000.
